// File: rtl/fetch_sequencer.sv
// Program-counter sequencer and fetch stage for the instruction ROM: owns the ROM
// address, registers the fetched word for the decoder and applies start/stall/branch/halt.
module fetch_sequencer #(
    parameter int NUM_INSTR = 128,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [6:0]       start_addr,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [6:0]       branch_target,
    input  logic             halt,
    input  logic [8:0]       rom_data,
    output logic [6:0]       pc,
    output logic [8:0]       instr_out,
    output logic             instr_valid,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [CNT_W-1:0] cycle_count,
    output logic [1:0]       state_dbg
);

    // Handshake: there is no ready/valid back-pressure here; instr_out is consumed
    // whenever instr_valid=1, and stall=1 freezes the fetch stage for that cycle.
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, LAST = 2'd2, DONE = 2'd3} state_t;

    localparam logic [6:0]       LAST_ADDR = 7'(NUM_INSTR - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t state, state_next;

    logic start_ok, branch_ok, active;
    logic accept_start, bad_start, do_halt, do_branch, do_seq;

    always_comb begin
        start_ok     = 32'(start_addr) < NUM_INSTR;
        branch_ok    = 32'(branch_target) < NUM_INSTR;
        active       = (state == RUN) || (state == LAST);
        accept_start = !active && start && start_ok;
        bad_start    = !active && start && !start_ok;
        // halt and branch only act on a live instruction, halt winning over branch
        do_halt      = active && !stall && instr_valid && halt;
        do_branch    = active && !stall && instr_valid && !halt && branch_taken;
        do_seq       = active && !stall && !do_halt && !do_branch;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE: begin
                if (accept_start)   state_next = RUN;
                else if (bad_start) state_next = DONE;
            end
            RUN, LAST: begin
                if (do_halt)                          state_next = DONE;
                else if (do_branch)                   state_next = branch_ok ? RUN : DONE;
                else if (do_seq && state == LAST)     state_next = DONE;
                else if (do_seq && pc == LAST_ADDR)   state_next = LAST;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = active;
        done      = (state == DONE);
        state_dbg = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
            cycle_count <= '0;
        end else begin
            if (accept_start) begin
                pc          <= start_addr;
                cycle_count <= '0;
                fault       <= 1'b0;
            end
            if (bad_start) fault <= 1'b1;
            if (!active) instr_valid <= 1'b0;
            // counting continues through stalls; it only stops at saturation
            if (active && cycle_count != CNT_MAX) cycle_count <= cycle_count + 1'b1;
            if (do_halt) instr_valid <= 1'b0;
            if (do_branch) begin
                instr_valid <= 1'b0;
                if (branch_ok) pc    <= branch_target;
                else           fault <= 1'b1;
            end
            if (do_seq) begin
                if (state == RUN) begin
                    instr_out   <= rom_data;
                    instr_valid <= 1'b1;
                    if (pc != LAST_ADDR) pc <= pc + 7'd1;
                end else begin
                    instr_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random control traffic, all
// outputs compared every cycle against a behavioural model of the program runner.
module tb_fetch_sequencer;

    localparam int NI    = 100;
    localparam int CW    = 6;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [6:0]    start_addr = '0;
    logic          stall = 1'b0;
    logic          branch_taken = 1'b0;
    logic [6:0]    branch_target = '0;
    logic          halt = 1'b0;
    logic [8:0]    rom_data;
    logic [6:0]    pc;
    logic [8:0]    instr_out;
    logic          instr_valid, busy, done, fault;
    logic [CW-1:0] cycle_count;
    logic [1:0]    state_dbg;

    logic [8:0] rom [128];
    assign rom_data = rom[pc];

    fetch_sequencer #(.NUM_INSTR(NI), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .halt(halt), .rom_data(rom_data), .pc(pc), .instr_out(instr_out),
        .instr_valid(instr_valid), .busy(busy), .done(done), .fault(fault),
        .cycle_count(cycle_count), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [8:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: mode 0 idle, 1 running, 2 finished
    int         m_mode;
    bit         m_at_end;
    int         m_pc;
    logic [8:0] m_instr;
    bit         m_valid, m_fault;
    int         m_cnt;

    task automatic model_reset();
        m_mode = 0; m_at_end = 0; m_pc = 0; m_instr = 0;
        m_valid = 0; m_fault = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        if (m_mode != 1) begin
            m_valid = 0;
            if (start) begin
                if (int'(start_addr) < NI) begin
                    m_pc = int'(start_addr); m_cnt = 0; m_fault = 0;
                    m_mode = 1; m_at_end = 0;
                end else begin
                    m_fault = 1; m_mode = 2;
                end
            end
        end else begin
            if (m_cnt < CMAX) m_cnt++;
            if (stall) begin
            end else if (m_valid && halt) begin
                m_mode = 2; m_valid = 0;
            end else if (m_valid && branch_taken) begin
                m_valid = 0;
                if (int'(branch_target) < NI) begin
                    m_pc = int'(branch_target); m_at_end = 0;
                end else begin
                    m_fault = 1; m_mode = 2;
                end
            end else if (m_at_end) begin
                m_valid = 0; m_mode = 2;
            end else begin
                m_instr = rom[m_pc];
                m_valid = 1;
                if (m_pc == NI - 1) m_at_end = 1;
                else                m_pc++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},    32'(pc), 32'(m_pc));
        check({tag, ".valid"}, 32'(instr_valid), 32'(m_valid));
        if (m_valid) check({tag, ".instr"}, 32'(instr_out), 32'(m_instr));
        check({tag, ".busy"},  32'(busy), 32'(m_mode == 1));
        check({tag, ".done"},  32'(done), 32'(m_mode == 2));
        check({tag, ".fault"}, 32'(fault), 32'(m_fault));
        check({tag, ".cnt"},   32'(cycle_count), 32'(m_cnt));
    endtask

    // driver tasks
    task automatic cyc(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic quiet();
        start = 0; stall = 0; branch_taken = 0; halt = 0;
    endtask

    task automatic launch(input logic [6:0] a, input string tag);
        start = 1; start_addr = a;
        cyc(tag);
        start = 0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 9'(i);
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1;

        // start at 5, consecutive words, start ignored while busy, then halt
        launch(7'd5, "start5");
        check("start5_pc", 32'(pc), 32'd5);
        exp_q = {9'd5, 9'd6, 9'd7};
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin start = 1; start_addr = 7'd50; end
            cyc("stream");
            start = 0;
            check("stream_word", 32'(instr_out), 32'(exp_q.pop_front()));
        end
        halt = 1; cyc("halt5"); halt = 0;
        check("halt5_done", 32'(done), 32'd1);

        // sequential run to the end of the ROM
        launch(7'(NI - 3), "end_start");
        for (int i = 0; i < 4; i++) cyc("end_run");
        check("end_done", 32'(done), 32'd1);
        check("end_fault", 32'(fault), 32'd0);
        check("end_pc", 32'(pc), 32'(NI - 1));
        check("end_cnt", 32'(cycle_count), 32'd4);

        // branch ignored on a bubble, then taken from word 8
        start = 1; start_addr = 7'd3; branch_taken = 1; branch_target = 7'd60;
        cyc("br_start");
        start = 0;
        cyc("br_bubble_ignored");
        branch_taken = 0;
        for (int i = 0; i < 20 && !(m_valid && m_instr == 9'd8); i++) cyc("br_seek");
        check("br_at8", 32'(instr_out), 32'd8);
        branch_taken = 1; branch_target = 7'd20;
        cyc("br_take");
        branch_taken = 0;
        check("br_bubble", 32'(instr_valid), 32'd0);
        cyc("br_target");
        check("br_word", 32'(instr_out), 32'd20);

        // stall with halt pending, then halt after release
        stall = 1; halt = 1;
        for (int i = 0; i < 3; i++) cyc("stall");
        stall = 0;
        cyc("stall_halt");
        halt = 0;
        check("stall_done", 32'(done), 32'd1);

        // faults: illegal start, illegal branch, cleared by a legal start
        launch(7'd110, "bad_start");
        check("bad_start_fault", 32'(fault), 32'd1);
        launch(7'd10, "clear_start");
        check("clear_fault", 32'(fault), 32'd0);
        cyc("pre_bad_br");
        branch_taken = 1; branch_target = 7'd120;
        cyc("bad_br");
        branch_taken = 0;
        check("bad_br_fault", 32'(fault), 32'd1);
        launch(7'd0, "sat_start");

        // counter saturation under a long stall
        stall = 1;
        for (int i = 0; i < CMAX + 8; i++) cyc("sat");
        check("sat_cnt", 32'(cycle_count), 32'(CMAX));
        stall = 0; cyc("sat_rel");
        halt = 1; cyc("sat_halt"); halt = 0;

        // asynchronous reset mid-run
        launch(7'd40, "ar_start");
        cyc("ar_run");
        #2 rst_n = 0;
        #1 model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1;
        cyc("ar_idle");

        // random traffic
        for (int i = 0; i < 128; i++) rom[i] = 9'($urandom_range(0, 511));
        for (int i = 0; i < 600; i++) begin
            start         = ($urandom_range(0, 9) == 0);
            start_addr    = 7'($urandom_range(0, 127));
            stall         = ($urandom_range(0, 3) == 0);
            halt          = ($urandom_range(0, 24) == 0);
            branch_taken  = ($urandom_range(0, 7) == 0);
            branch_target = 7'($urandom_range(0, 127));
            cyc("rand");
        end
        quiet();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter sequencer and fetch stage for the 128-entry, 9-bit instruction ROM. It owns the 7-bit ROM address, registers the combinational ROM output into an instruction register for the decoder, and applies start, stall, branch and halt control. It runs one program per `start`, reports completion and faults, and counts execution cycles for performance reporting.

## Interface
- `NUM_INSTR`, 128: number of valid ROM words; legal addresses are 0..NUM_INSTR-1.
- `CNT_W`, 16: width of the cycle counter.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch the program at `start_addr`; honoured only in IDLE or DONE.
- `start_addr`  in  7  first PC of the program.
- `stall`  in  1  downstream hold; freezes PC, state and instruction register.
- `branch_taken`  in  1  decoder redirect for the instruction in `instr_out`.
- `branch_target`  in  7  absolute redirect address.
- `halt`  in  1  decoder halt for the instruction in `instr_out`.
- `rom_data`  in  9  combinational ROM word at `pc`.
- `pc`  out  7  ROM address.
- `instr_out`  out  9  registered instruction.
- `instr_valid`  out  1  `instr_out` is live this cycle.
- `busy`  out  1  high in RUN or LAST.
- `done`  out  1  high in DONE (level, until the next accepted `start`).
- `fault`  out  1  set on an illegal start or branch address; cleared by an accepted `start`.
- `cycle_count`  out  CNT_W  cycles spent in RUN or LAST; saturating.

## Operation
- States: IDLE, RUN, LAST, DONE.
- Reset, async, in any state: state=IDLE, pc=0, instr_out=0, instr_valid=0, busy=0, done=0, fault=0, cycle_count=0.
- IDLE/DONE with `start`=1:
  - If `start_addr`<NUM_INSTR: pc<=start_addr, cycle_count<=0, fault<=0, go to RUN.
  - Otherwise: fault<=1, go to (or stay in) DONE.
  - `stall` does not block `start`.
- IDLE/DONE otherwise: instr_valid=0; `branch_taken`/`halt` ignored.
- RUN/LAST priority per cycle: `stall` > `halt` > `branch_taken` > sequential.
  - `halt` and `branch_taken` are honoured only while `instr_valid`=1.
- Stall: pc, state, instr_out, instr_valid held; cycle_count still increments.
- Halt: go to DONE, instr_valid<=0 (squashes the word at `pc`).
- Branch, `branch_target`<NUM_INSTR: pc<=branch_target, instr_valid<=0 (one-cycle bubble), state RUN.
- Branch, `branch_target`>=NUM_INSTR: fault<=1, go to DONE, instr_valid<=0.
- Sequential in RUN: instr_out<=rom_data, instr_valid<=1.
  - If pc<NUM_INSTR-1: pc<=pc+1.
  - If pc=NUM_INSTR-1: pc held, go to LAST. The PC never wraps.
- Sequential in LAST: instr_valid<=0, go to DONE. This is a normal finish with `fault`=0.
  - LAST exists so the final word can still branch or halt.
- `start` in RUN/LAST is ignored.
- cycle_count: +1 per cycle in RUN or LAST, saturates at 2^CNT_W-1.

## Timing
- `pc`, `busy`, `done` and `fault` are registered or decoded from state only; no output depends combinationally on any input.
- Start latency:
  - `start` sampled at edge 0.
  - pc=start_addr and busy=1 from edge 0.
  - instr_out=ROM[start_addr] with instr_valid=1 from edge 1.
- Throughput: one instruction per cycle without stall or branch.
- Branch penalty: exactly one invalid cycle. The target word is valid two edges after the branch edge.
- `done` rises on the edge that follows halt, LAST, or a fault.
- Reset mid-run aborts immediately; the next run requires `start`.

## Test plan
- Reset, then start with start_addr=5 and ROM[n]=n: pc=5 one cycle later; instr_out=5,6,7 valid on consecutive cycles; busy=1.
- Sequential run to end: start at 125 → words 125,126,127 valid; one LAST cycle with valid=0; done=1, fault=0, pc=127, cycle_count=4.
- Branch: branch_taken with target=20 while instr_out=8 → next cycle instr_valid=0; following cycle instr_out=20 valid. branch_taken while instr_valid=0 has no effect.
- Stall held 3 cycles during RUN: pc and instr_out frozen, cycle_count +3. A simultaneous halt under stall is ignored; halt after stall releases → done=1.
- Fault: with NUM_INSTR=100, start_addr=110 → done=1, fault=1, busy=0. Branch to 120 during a run → fault=1, done=1. A later legal start clears fault.
- Async reset: rst_n low mid-cycle during RUN → all outputs 0 immediately, without waiting for a clock edge. start while busy is ignored.
